cm_config_sequencer: RTL and testbench
======================================

# cm_config_sequencer

Sequences configuration and execution of the homogeneous PE array. It accepts a valid/ready stream of control-memory words from the host and writes each one into the addressed tile's control memory, using active-low per-tile enables. It then holds `start_exec` for a programmed number of cycles and reports completion. It sits between the host/scan interface and `peArray`, replacing the ad-hoc top-level `cm_en`, `cm_data` and `start_exec` drive.

## Interface
- `NUM_TILES`, 36, number of tiles (6x6 array)
- `TILE_ID_BITS`, 6, width of the tile index
- `CM_WIDTH`, 64, control-memory word width
- `CM_DEPTH_BITS`, 4, control-memory address width
- `RUN_BITS`, 16, execution cycle-counter width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `cfg_valid`  in  1  host word valid
- `cfg_ready`  out  1  sequencer can accept a word
- `cfg_tile`  in  TILE_ID_BITS  target tile, row-major (i*6+j)
- `cfg_addr`  in  CM_DEPTH_BITS  control-memory address
- `cfg_data`  in  CM_WIDTH  control-memory word
- `cfg_last`  in  1  final word of the configuration
- `run_cycles`  in  RUN_BITS  execution length, sampled with the `cfg_last` word
- `abort`  in  1  terminate execution
- `err_clr`  in  1  clear sticky error
- `cm_en_n`  out  NUM_TILES  per-tile control-memory enable, active-low
- `cm_wr_n`  out  1  control-memory write strobe, active-low
- `cm_addr`  out  CM_DEPTH_BITS  write address
- `cm_data`  out  CM_WIDTH  write data
- `start_exec`  out  1  array execute
- `busy`  out  1  not in IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky bad-tile error

## Operation
- States: IDLE, LOAD, WRITE, RUN, DONE.
- Reset values: state IDLE; `cm_en_n` all ones; `cm_wr_n`=1; `cm_addr`=0; `cm_data`=0; `start_exec`=0; `busy`=0; `done`=0; `err`=0; run counter 0.
- `cfg_ready`=1 in IDLE and LOAD only, 0 elsewhere.
- A word is accepted when `cfg_valid` && `cfg_ready`.
- Accept in IDLE or LOAD with `cfg_tile` < NUM_TILES:
  - Register `cm_addr` and `cm_data`.
  - Drive `cm_en_n[cfg_tile]`=0 with all other bits 1, and `cm_wr_n`=0.
  - Go to WRITE.
- Accept with `cfg_tile` >= NUM_TILES:
  - The word is dropped; no enable asserts.
  - `err` is set.
  - State goes to LOAD, or takes the `cfg_last` path if `cfg_last`=1.
- WRITE lasts exactly one cycle. Exit: `cm_en_n` all ones, `cm_wr_n`=1, then:
  - latched last=0 -> LOAD;
  - latched last=1, latched run_cycles != 0 -> RUN with `start_exec`=1 and counter = run_cycles;
  - latched last=1, run_cycles == 0 -> DONE.
- RUN:
  - Counter decrements each cycle.
  - When counter==1, `start_exec` drops next cycle and state goes to DONE. `start_exec` is therefore high for exactly run_cycles cycles.
- `abort` in RUN: next cycle `start_exec`=0, state IDLE, no `done`.
- `abort` in any other state is ignored.
- DONE: `done`=1 for one cycle, then IDLE.
- `err`:
  - `err_clr` clears it.
  - If a set and a clear occur in the same cycle, set wins.
- `cm_addr` and `cm_data` hold their last values outside WRITE.
- `busy` = (state != IDLE).

## Timing
- Accept at edge N -> enable/strobe visible in cycle N+1 for exactly one cycle -> `cfg_ready` high again in cycle N+2. Maximum throughput is one word per 2 cycles.
- Last word accepted at N -> `start_exec` high in cycles N+2 .. N+1+run_cycles -> `done` in cycle N+2+run_cycles.
- With run_cycles=0: `done` in cycle N+2; `start_exec` never asserts.
- A bad-tile word accepted at N sets `err` in cycle N+1; `cfg_ready` stays high in N+1.
- `reset` mid-WRITE or mid-RUN: all outputs return to reset values at the next edge, and the partially loaded configuration is abandoned.
- `cfg_valid` with `cfg_ready`=0 is ignored; the host holds the word.

## Test plan
- Load tile 0 addr 3 data 0xDEAD_BEEF, last=0 -> for one cycle `cm_en_n`=~36'h1, `cm_wr_n`=0, `cm_addr`=3, `cm_data`=0xDEADBEEF; `cfg_ready` returns 2 cycles after accept.
- Stream 36 words, one per tile with back-to-back valid, the last with run_cycles=10 -> each `cm_en_n` bit strobes once in order; `start_exec` high for exactly 10 cycles; `done` pulses once; `busy` falls with `done`.
- Word with tile=40 -> no enable asserts, `err`=1 and stays 1 through later good words until `err_clr`; `err` and `err_clr` in the same cycle keeps `err`=1.
- Last word with run_cycles=0 -> `start_exec` never high; `done` 2 cycles after accept.
- run_cycles=100, `abort` at RUN cycle 5 -> `start_exec` low next cycle, state IDLE, no `done`.
- `reset` during RUN cycle 3 -> next cycle `start_exec`=0, `cm_en_n` all ones, `busy`=0, `err`=0.

Source files
------------

// File: rtl/cm_config_sequencer.sv
// Loads host control-memory words into the PE array tiles over active-low
// per-tile enables, then drives start_exec for a programmed cycle count.
module cm_config_sequencer #(
  parameter int NUM_TILES     = 36,
  parameter int TILE_ID_BITS  = 6,
  parameter int CM_WIDTH      = 64,
  parameter int CM_DEPTH_BITS = 4,
  parameter int RUN_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [TILE_ID_BITS-1:0]  cfg_tile,
  input  logic [CM_DEPTH_BITS-1:0] cfg_addr,
  input  logic [CM_WIDTH-1:0]      cfg_data,
  input  logic                     cfg_last,
  input  logic [RUN_BITS-1:0]      run_cycles,
  input  logic                     abort,
  input  logic                     err_clr,
  output logic [NUM_TILES-1:0]     cm_en_n,
  output logic                     cm_wr_n,
  output logic [CM_DEPTH_BITS-1:0] cm_addr,
  output logic [CM_WIDTH-1:0]      cm_data,
  output logic                     start_exec,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, DONE} state_t;

  // One extra bit so a tile count equal to 2**TILE_ID_BITS still compares correctly.
  localparam logic [TILE_ID_BITS:0]  TILE_LIMIT = NUM_TILES[TILE_ID_BITS:0];
  localparam logic [NUM_TILES-1:0]   TILE_ONE   = {{(NUM_TILES-1){1'b0}}, 1'b1};
  localparam logic [RUN_BITS-1:0]    RUN_ONE    = {{(RUN_BITS-1){1'b0}}, 1'b1};

  state_t              state;
  logic                last_q;
  logic [RUN_BITS-1:0] run_q;
  logic [RUN_BITS-1:0] run_cnt;
  logic                accept;
  logic                tile_ok;
  logic                err_set;

  assign cfg_ready = (state == IDLE) || (state == LOAD);
  assign accept    = cfg_valid && cfg_ready;
  assign tile_ok   = {1'b0, cfg_tile} < TILE_LIMIT;
  assign err_set   = accept && !tile_ok;

  // A dropped last word still passes through WRITE (with no strobe) so the
  // start/done timing matches that of a good last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cm_en_n    <= '1;
      cm_wr_n    <= 1'b1;
      cm_addr    <= '0;
      cm_data    <= '0;
      start_exec <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      run_cnt    <= '0;
      run_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      done    <= 1'b0;
      cm_en_n <= '1;
      cm_wr_n <= 1'b1;

      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;

      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            last_q <= cfg_last;
            run_q  <= run_cycles;
            busy   <= 1'b1;
            if (tile_ok) begin
              cm_addr <= cfg_addr;
              cm_data <= cfg_data;
              cm_en_n <= ~(TILE_ONE << cfg_tile);
              cm_wr_n <= 1'b0;
              state   <= WRITE;
            end else if (cfg_last) begin
              state <= WRITE;
            end else begin
              state <= LOAD;
            end
          end
        end

        WRITE: begin
          if (!last_q) begin
            state <= LOAD;
          end else if (run_q != '0) begin
            state      <= RUN;
            start_exec <= 1'b1;
            run_cnt    <= run_q;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        RUN: begin
          if (abort) begin
            state      <= IDLE;
            start_exec <= 1'b0;
            busy       <= 1'b0;
            run_cnt    <= '0;
          end else begin
            run_cnt <= run_cnt - RUN_ONE;
            if (run_cnt == RUN_ONE) begin
              state      <= DONE;
              start_exec <= 1'b0;
              done       <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          start_exec <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cm_config_sequencer.sv
// Directed bench for cm_config_sequencer: single write, 36-word stream with run,
// bad-tile error handling, zero-length run, abort and reset during RUN.
module tb_cm_config_sequencer;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [5:0]  cfg_tile;
  logic [3:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic        cfg_last;
  logic [15:0] run_cycles;
  logic        abort;
  logic        err_clr;
  logic [35:0] cm_en_n;
  logic        cm_wr_n;
  logic [3:0]  cm_addr;
  logic [63:0] cm_data;
  logic        start_exec;
  logic        busy;
  logic        done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [35:0] ALL_OFF = {36{1'b1}};

  cm_config_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_tile   (cfg_tile),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .run_cycles (run_cycles),
    .abort      (abort),
    .err_clr    (err_clr),
    .cm_en_n    (cm_en_n),
    .cm_wr_n    (cm_wr_n),
    .cm_addr    (cm_addr),
    .cm_data    (cm_data),
    .start_exec (start_exec),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_word(input logic [5:0] tile, input logic [3:0] addr,
                            input logic [63:0] data, input logic last,
                            input logic [15:0] runs);
    cfg_valid  = 1'b1;
    cfg_tile   = tile;
    cfg_addr   = addr;
    cfg_data   = data;
    cfg_last   = last;
    run_cycles = runs;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++; if (cm_en_n !== ALL_OFF) begin miscompares++; $display("[TB] FAIL reset_en got %h want %h", cm_en_n, ALL_OFF); end
    vectors++; if (cm_wr_n !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_wr got %b want 1", cm_wr_n); end
    vectors++; if (cm_addr !== 4'd0 || cm_data !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_addr_data got %h/%h want 0/0", cm_addr, cm_data); end
    vectors++; if ({start_exec, busy, done, err} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags got %b want 0000", {start_exec, busy, done, err}); end
    reset = 1'b0;
    step();
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", cfg_ready); end
  endtask

  task automatic test_single_write();
    drive_word(6'd0, 4'd3, 64'hDEAD_BEEF, 1'b0, 16'd0);
    step();
    cfg_valid = 1'b0;
    vectors++; if (cm_en_n !== ~36'h1) begin miscompares++; $display("[TB] FAIL single_en got %h want %h", cm_en_n, ~36'h1); end
    vectors++; if (cm_wr_n !== 1'b0) begin miscompares++; $display("[TB] FAIL single_wr got %b want 0", cm_wr_n); end
    vectors++; if (cm_addr !== 4'd3) begin miscompares++; $display("[TB] FAIL single_addr got %h want 3", cm_addr); end
    vectors++; if (cm_data !== 64'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL single_data got %h want deadbeef", cm_data); end
    vectors++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_ready_busy got %b%b want 01", cfg_ready, busy); end
    step();
    vectors++; if (cm_en_n !== ALL_OFF || cm_wr_n !== 1'b1) begin miscompares++; $display("[TB] FAIL single_release got %h/%b want all-ones/1", cm_en_n, cm_wr_n); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL single_ready_back got %b want 1", cfg_ready); end
    vectors++; if (cm_addr !== 4'd3 || cm_data !== 64'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL single_hold got %h/%h want 3/deadbeef", cm_addr, cm_data); end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp_en;
    logic [63:0] exp_data;
    logic [3:0]  exp_addr;
    for (int i = 0; i < 36; i++) begin
      vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_ready[%0d] got %b want 1", i, cfg_ready); end
      exp_data = 64'hC0DE_0000_0000_0000 | 64'(i);
      exp_addr = 4'(i);
      exp_en   = ~(36'd1 << i);
      drive_word(6'(i), exp_addr, exp_data, (i == 35), 16'd10);
      step();
      vectors++; if (cm_en_n !== exp_en || cm_wr_n !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_en[%0d] got %h/%b want %h/0", i, cm_en_n, cm_wr_n, exp_en); end
      vectors++; if (cm_addr !== exp_addr || cm_data !== exp_data) begin miscompares++; $display("[TB] FAIL stream_word[%0d] got %h/%h want %h/%h", i, cm_addr, cm_data, exp_addr, exp_data); end
      vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_busy_ready[%0d] got %b want 0", i, cfg_ready); end
      // Next word stays presented while ready is low; it must not be taken early.
      if (i < 35) drive_word(6'(i + 1), 4'(i + 1), 64'hC0DE_0000_0000_0000 | 64'(i + 1), (i + 1 == 35), 16'd10);
      else cfg_valid = 1'b0;
      step();
    end
    // Now in cycle N+2 after the last accept.
    for (int k = 2; k <= 14; k++) begin
      vectors++; if (start_exec !== (k <= 11)) begin miscompares++; $display("[TB] FAIL stream_start[N+%0d] got %b want %b", k, start_exec, (k <= 11)); end
      vectors++; if (done !== (k == 12)) begin miscompares++; $display("[TB] FAIL stream_done[N+%0d] got %b want %b", k, done, (k == 12)); end
      vectors++; if (busy !== (k <= 12)) begin miscompares++; $display("[TB] FAIL stream_busy[N+%0d] got %b want %b", k, busy, (k <= 12)); end
      vectors++; if (cm_en_n !== ALL_OFF) begin miscompares++; $display("[TB] FAIL stream_en_idle[N+%0d] got %h want all-ones", k, cm_en_n); end
      step();
    end
  endtask

  task automatic test_bad_tile();
    drive_word(6'd40, 4'd1, 64'h1111, 1'b0, 16'd0);
    step();
    cfg_valid = 1'b0;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_err got %b want 1", err); end
    vectors++; if (cm_en_n !== ALL_OFF || cm_wr_n !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_no_en got %h/%b want all-ones/1", cm_en_n, cm_wr_n); end
    vectors++; if (cfg_ready !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_ready_busy got %b%b want 11", cfg_ready, busy); end
    drive_word(6'd5, 4'd2, 64'h2222, 1'b0, 16'd0);
    step();
    cfg_valid = 1'b0;
    vectors++; if (cm_en_n !== ~(36'd1 << 5)) begin miscompares++; $display("[TB] FAIL bad_good_en got %h want %h", cm_en_n, ~(36'd1 << 5)); end
    step();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_err_sticky got %b want 1", err); end
    drive_word(6'd63, 4'd0, 64'h3333, 1'b0, 16'd0);
    err_clr = 1'b1;
    step();
    cfg_valid = 1'b0;
    err_clr   = 1'b0;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_set_wins got %b want 1", err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL bad_clear got %b want 0", err); end
  endtask

  task automatic test_zero_run();
    drive_word(6'd2, 4'd4, 64'h4444, 1'b1, 16'd0);
    step();
    cfg_valid = 1'b0;
    vectors++; if (cm_en_n !== ~(36'd1 << 2) || start_exec !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_write got %h/%b want %h/0", cm_en_n, start_exec, ~(36'd1 << 2)); end
    step();
    vectors++; if (done !== 1'b1 || start_exec !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_done got d%b s%b b%b want d1 s0 b1", done, start_exec, busy); end
    step();
    vectors++; if (done !== 1'b0 || busy !== 1'b0 || start_exec !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_idle got d%b b%b s%b want 000", done, busy, start_exec); end
  endtask

  task automatic test_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_idle_ignored got b%b r%b want b0 r1", busy, cfg_ready); end
    drive_word(6'd7, 4'd5, 64'h5555, 1'b1, 16'd100);
    step();
    cfg_valid = 1'b0;
    // RUN cycle k is cycle N+1+k.
    for (int k = 1; k <= 5; k++) begin
      step();
      vectors++; if (start_exec !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_run[%0d] got %b want 1", k, start_exec); end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++; if (start_exec !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_stop got s%b b%b r%b want s0 b0 r1", start_exec, busy, cfg_ready); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (done !== 1'b0 || start_exec !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_no_done[%0d] got d%b s%b want 00", k, done, start_exec); end
      step();
    end
  endtask

  task automatic test_reset_mid_run();
    drive_word(6'd50, 4'd0, 64'h6666, 1'b0, 16'd0);
    step();
    drive_word(6'd3, 4'd6, 64'h7777, 1'b1, 16'd20);
    step();
    cfg_valid = 1'b0;
    vectors++; if (err !== 1'b1 || cm_en_n !== ~(36'd1 << 3)) begin miscompares++; $display("[TB] FAIL rst_setup got e%b en %h want e1 en %h", err, cm_en_n, ~(36'd1 << 3)); end
    for (int k = 1; k <= 3; k++) step();
    vectors++; if (start_exec !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_running got %b want 1", start_exec); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (start_exec !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_flags got s%b b%b e%b d%b want 0000", start_exec, busy, err, done); end
    vectors++; if (cm_en_n !== ALL_OFF || cm_wr_n !== 1'b1 || cm_addr !== 4'd0 || cm_data !== 64'd0) begin miscompares++; $display("[TB] FAIL rst_cm got %h/%b/%h/%h want reset values", cm_en_n, cm_wr_n, cm_addr, cm_data); end
    step();
    vectors++; if (cfg_ready !== 1'b1 || busy !== 1'b0 || start_exec !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_after got r%b b%b s%b want r1 b0 s0", cfg_ready, busy, start_exec); end
  endtask

  initial begin
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_tile   = '0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_last   = 1'b0;
    run_cycles = '0;
    abort      = 1'b0;
    err_clr    = 1'b0;
    step();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_bad_tile();
    test_zero_run();
    test_abort();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
